// File: rtl/enum_seq_pkg.sv
// Shared types and member/ordinal mapping for the enum sequence emitter.
// Members in declaration order: TEN, ELEVEN, SIXTEEN.
package enum_seq_pkg;

    typedef enum int {
        TEN     = 10,
        ELEVEN  = 11,
        SIXTEEN = 16
    } enum_t;

    typedef logic [1:0] ord_t;

    localparam int N_MEMBERS = 3;

    function automatic logic signed [31:0] ord_to_val(input ord_t ord);
        logic signed [31:0] val;
        case (ord)
            2'd0:    val = int'(TEN);
            2'd1:    val = int'(ELEVEN);
            default: val = int'(SIXTEEN);
        endcase
        return val;
    endfunction

    // Full-width compare: only exact 32-bit matches are members.
    function automatic ord_t val_to_ord(input logic signed [31:0] val, output logic valid);
        ord_t ord;
        ord   = 2'd0;
        valid = 1'b1;
        case (val)
            int'(TEN):     ord = 2'd0;
            int'(ELEVEN):  ord = 2'd1;
            int'(SIXTEEN): ord = 2'd2;
            default:       valid = 1'b0;
        endcase
        return ord;
    endfunction

endpackage

// File: rtl/enum_ord_step.sv
// Combinational ordinal stepper with wrap: next 2->0, prev 0->2.
module enum_ord_step
    import enum_seq_pkg::*;
(
    input  logic [1:0] ord_i,
    input  logic       dir_i,
    output logic [1:0] ord_o
);

    localparam ord_t LAST_ORD = ord_t'(N_MEMBERS - 1);

    always_comb begin
        ord_o = ord_i;
        if (!dir_i) begin
            ord_o = (ord_i >= LAST_ORD) ? 2'd0 : ord_i + 2'd1;
        end else begin
            ord_o = (ord_i == 2'd0) ? LAST_ORD : ord_i - 2'd1;
        end
    end

endmodule

// File: rtl/enum_seq_emitter.sv
// Emits enum member values starting at a commanded value, stepping next/prev
// in declaration order; illegal start values are rejected with an err pulse.
module enum_seq_emitter
    import enum_seq_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_value,
    input  logic               cmd_dir,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_value,
    output logic [1:0]         out_index,
    output logic               out_last,
    output logic               err,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    ord_t                ord_q, ord_d;
    logic                dir_q, dir_d;
    logic [COUNT_W-1:0]  remain_q, remain_d;
    logic signed [31:0]  value_q, value_d;
    logic                last_q, last_d;
    logic                err_q, err_d;

    logic                accept;
    logic                cmd_legal;
    ord_t                cmd_ord;
    ord_t                step_ord;

    enum_ord_step u_step (
        .ord_i (ord_q),
        .dir_i (dir_q),
        .ord_o (step_ord)
    );

    always_comb begin
        accept   = cmd_valid && (state_q == IDLE);
        cmd_ord  = val_to_ord($signed(cmd_value), cmd_legal);

        state_d  = state_q;
        ord_d    = ord_q;
        dir_d    = dir_q;
        remain_d = remain_q;
        value_d  = value_q;
        last_d   = last_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!cmd_legal) begin
                        err_d = 1'b1;
                    end else if (cmd_count != '0) begin
                        state_d  = EMIT;
                        ord_d    = cmd_ord;
                        dir_d    = cmd_dir;
                        remain_d = cmd_count;
                        value_d  = ord_to_val(cmd_ord);
                        last_d   = (cmd_count == COUNT_W'(1));
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        // remain_q >= 2 here, so the decrement cannot underflow.
                        ord_d    = step_ord;
                        value_d  = ord_to_val(step_ord);
                        remain_d = remain_q - COUNT_W'(1);
                        last_d   = (remain_q == COUNT_W'(2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ord_q    <= 2'd0;
            dir_q    <= 1'b0;
            remain_q <= '0;
            value_q  <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ord_q    <= ord_d;
            dir_q    <= dir_d;
            remain_q <= remain_d;
            value_q  <= value_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_value = value_q;
    assign out_index = ord_q;
    assign out_last  = last_q;
    assign err       = err_q;

endmodule
